// File: rtl/alu_seq_driver.sv
// -----------------------------------------------------------------------------
// alu_seq_driver
//
// Sequential command front-end for a 32-bit unsigned combinational ALU.
//
// A tagged command is accepted over a valid/ready handshake and registered
// onto the ALU input ports (issue stage). One cycle later the ALU's
// combinational result is captured into a response FIFO, which is returned
// over a second valid/ready handshake. A running carry register lets
// consecutive ADDs be chained into multi-word additions. A chained ADD that
// directly follows another ADD takes the carry forwarded from the ALU, so
// there is no bubble between words.
//
// Flow control is credit based. A command is accepted only when the FIFO
// entries plus the in-flight issue leave room for it. As a result, a push
// into a full FIFO cannot happen, and cmd_ready has no combinational
// dependence on rsp_ready.
//
// Optional feature (compile-time macro ALU_SEQ_ZERO_FLAG_EN):
//   defined   - each FIFO entry also stores (alu_result == 0), presented on
//               rsp_zero for the head entry.
//   undefined - no zero storage; rsp_zero is tied to 0.
//
// Parameters:
//   TAG_W      width of the command/response tag
//   RSP_DEPTH  response FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready   command handshake; accepted at edge with both high
//   cmd_op/a/b        ALU opcode (000 NOT ... 111 ADD) and operands
//   cmd_cin           carry-in for an unchained ADD
//   cmd_chain         ADD only: use the running carry instead of cmd_cin
//   cmd_tag           returned unchanged with the response
//   alu_opcode/a/b/cin  registered ALU inputs
//   alu_result/cout   combinational ALU outputs
//   rsp_valid/ready   response handshake; head popped at edge with both high
//   rsp_result/cout/zero/tag  FIFO head fields (don't-care while empty)
//   carry_q           running carry (last captured ADD carry-out)
//   busy              issue stage occupied or responses pending
// -----------------------------------------------------------------------------
module alu_seq_driver #(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_cin,
  input  logic             cmd_chain,
  input  logic [TAG_W-1:0] cmd_tag,

  output logic [2:0]       alu_opcode,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_cin,
  input  logic [31:0]      alu_result,
  input  logic             alu_cout,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,

  output logic             carry_q,
  output logic             busy
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(RSP_DEPTH);
  localparam logic [2:0] OpAdd = 3'b111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             iss_v_q, iss_v_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic             carry_d;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // FIFO storage (no reset needed; validity comes from count_q)
  logic [31:0]      res_mem [RSP_DEPTH];
  logic             cout_mem[RSP_DEPTH];
  logic [TAG_W-1:0] tag_mem [RSP_DEPTH];
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             zero_mem[RSP_DEPTH];
`endif

  // ---------------------------------------------------------------------------
  // Handshakes and credits
  // ---------------------------------------------------------------------------
  logic [OccW-1:0] occ;
  logic            accept;
  logic            push;
  logic            pop;
  logic            iss_is_add;
  logic            cin_res;

  // The in-flight issue counts against FIFO space, so a push always finds
  // room. This uses registered state only.
  assign occ        = {1'b0, count_q} + {{CntW{1'b0}}, iss_v_q};
  assign cmd_ready  = (occ < DepthOcc);
  assign accept     = cmd_valid & cmd_ready;

  assign rsp_valid  = (count_q != '0);
  assign push       = iss_v_q;
  assign pop        = rsp_valid & rsp_ready;
  assign busy       = iss_v_q | rsp_valid;

  assign iss_is_add = iss_v_q & (alu_opcode_q == OpAdd);

  // Resolve the carry-in at accept. A chained ADD right behind another ADD
  // takes the carry from the ALU this cycle, because carry_q only updates
  // at this edge.
  always_comb begin
    cin_res = 1'b0;
    if (cmd_op == OpAdd) begin
      if (!cmd_chain) begin
        cin_res = cmd_cin;
      end else if (iss_is_add) begin
        cin_res = alu_cout;
      end else begin
        cin_res = carry_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    iss_v_d      = accept;
    iss_tag_d    = iss_tag_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    if (accept) begin
      iss_tag_d    = cmd_tag;
      alu_opcode_d = cmd_op;
      alu_a_d      = cmd_a;
      alu_b_d      = cmd_b;
      alu_cin_d    = cin_res;
    end
  end

  always_comb begin
    carry_d = carry_q;
    if (iss_is_add) begin
      carry_d = alu_cout;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_q      <= 1'b0;
      iss_tag_q    <= '0;
      alu_opcode_q <= 3'b000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      carry_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      iss_v_q      <= iss_v_d;
      iss_tag_q    <= iss_tag_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      carry_q      <= carry_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Capture stage: the ALU output for the issued command is written at the
  // edge after issue.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr_q]  <= alu_result;
      cout_mem[wr_ptr_q] <= alu_cout;
      tag_mem[wr_ptr_q]  <= iss_tag_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_mem[wr_ptr_q] <= (alu_result == 32'd0);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;

  assign rsp_result = res_mem[rd_ptr_q];
  assign rsp_cout   = cout_mem[rd_ptr_q];
  assign rsp_tag    = tag_mem[rd_ptr_q];
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero   = zero_mem[rd_ptr_q];
`else
  assign rsp_zero   = 1'b0;
`endif

endmodule
